chnl_rx_node: RTL and testbench
===============================

// Module: chnl_rx_node
// PURPOSE
//  Receiving end of the 8-bit channel valid/ready interface; the DUT side that the channel driver talks to.
//  Accepts ch_data when ch_valid & ch_ready, buffers it in a first-word-fall-through FIFO,
//  and presents it to the downstream arbiter over a valid/ready port.
//  Drives rcv_vld as the per-cycle accept indicator sampled by the channel monitor.
// PARAMETERS
//  DATA_W   8    channel data width (must equal chnl_pkg::CHNL_DATA_W)
//  DEPTH    32   FIFO depth in words; power of two, >= 2
//  AW       $clog2(DEPTH)   pointer width (derived, not overridden)
//  CNT_W    16   width of accepted-word counter
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rstn       in   1        synchronous, active-low reset
//  en         in   1        channel enable; 0 blocks new accepts, drain continues
//  ch_data    in   DATA_W   channel data
//  ch_valid   in   1        channel data valid
//  ch_ready   out  1        node can accept this cycle
//  rcv_vld    out  1        word accepted this cycle (= ch_valid & ch_ready)
//  out_data   out  DATA_W   head-of-FIFO word
//  out_valid  out  1        FIFO not empty
//  out_ready  in   1        downstream consumes head when out_valid
//  margin     out  AW+1     free slots = DEPTH - count
//  acc_cnt    out  CNT_W    total accepted words, wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (rstn=0 at posedge): wptr=rptr=0, count=0, acc_cnt=0.
//   After reset: out_valid=0, margin=DEPTH, out_data don't-care.
//   While rstn=0: ch_ready=0, rcv_vld=0 (gated combinationally).
//  ch_ready = rstn & en & (count != DEPTH); no combinational path from ch_valid or out_ready.
//  push = ch_valid & ch_ready; rcv_vld = push (same cycle, monitor samples ch_data with it).
//  pop  = out_valid & out_ready; out_valid = (count != 0); out_data = mem[rptr].
//  Latency: word pushed at edge N appears on out_data/out_valid in the cycle after edge N.
//  No bypass: an empty FIFO never presents ch_data combinationally.
//  Push only: count+1, wptr+1. Pop only: count-1, rptr+1. Both: count unchanged, both ptrs +1.
//  Full (count=DEPTH): ch_ready=0, even if pop occurs same cycle (no full-bypass).
//  Empty: out_valid=0; out_ready ignored, no underflow possible.
//  Pointers AW bits, wrap DEPTH-1 -> 0 naturally; count AW+1 bits.
//  ch_valid held while ch_ready=0: data must stay stable (driver rule); node only samples on push.
//  en falls mid-stream: ch_ready drops same cycle, no word lost, buffered words still drain.
//  acc_cnt += 1 on every push, wraps to 0; margin registered-derived from count.
//  Reset mid-operation: all buffered data discarded; out_valid=0 the cycle after the reset edge.
//  Assertions: no push when count=DEPTH, no pop when count=0, count==wptr-rptr mod DEPTH.
// STRUCTURE
//  chnl_pkg: CHNL_DATA_W=8, typedef logic [CHNL_DATA_W-1:0] chnl_data_t, default DEPTH const.
//  Sub-module chnl_sync_fifo (FWFT, clk/rstn, push/pop, full/empty/count);
//   chnl_rx_node adds en gating, rcv_vld, margin, acc_cnt.
// TESTING
//  1 Reset: rstn=0 3 cycles, ch_valid=1 -> ch_ready=0, rcv_vld=0; release -> margin=32, out_valid=0.
//  2 Single word: en=1, push 0xA5 at edge N, out_ready=0
//    -> out_valid=1, out_data=0xA5 after N; margin=31, acc_cnt=1.
//  3 Fill: 32 back-to-back pushes 0x00..0x1F, out_ready=0
//    -> ch_ready=0 after 32nd, margin=0; hold ch_valid 5 cycles -> no rcv_vld;
//    out_ready=1 -> pops 0x00..0x1F in order.
//  4 Full + pop same cycle: count=32, out_ready=1, ch_valid=1
//    -> that cycle ch_ready=0 (no push), count=31; next cycle push allowed.
//  5 Streaming: ch_valid=1 and out_ready=1 continuous, 100 words, random data
//    -> count stays 1, order preserved, acc_cnt=100.
//  6 en=0 with 4 words buffered -> ch_ready=0 immediately, 4 words drain;
//    rstn=0 mid-drain -> out_valid=0, margin=32.

Source files
------------

// File: rtl/chnl_pkg.sv
// ============================================================================
// Module : chnl_pkg
// Brief  : Shared width, type and depth constants for the 8-bit channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package chnl_pkg;
   localparam int CHNL_DATA_W = 8;
   localparam int CHNL_DEPTH  = 32;
   typedef logic [CHNL_DATA_W-1:0] chnl_data_t;
endpackage

`default_nettype wire

// File: rtl/chnl_sync_fifo.sv
// ============================================================================
// Module : chnl_sync_fifo
// Brief  : Single-clock first-word-fall-through FIFO with occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chnl_sync_fifo
   import chnl_pkg::*;
#(
   parameter  int DATA_W = CHNL_DATA_W,
   parameter  int DEPTH  = CHNL_DEPTH,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push) r_wptr <= r_wptr + 1'b1;
         if (pop)  r_rptr <= r_rptr + 1'b1;
         if (push && !pop)      r_count <= r_count + 1'b1;
         else if (pop && !push) r_count <= r_count - 1'b1;
      end
   end

   // Storage carries no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wptr] <= wdata;
   end

   assign rdata = r_mem[r_rptr];
   assign full  = (r_count == c_DEPTH);
   assign empty = (r_count == '0);
   assign count = r_count;

   a_no_overflow  : assert property (@(posedge clk) disable iff (!rstn) !(push && full));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));
   a_ptr_count    : assert property (@(posedge clk) disable iff (!rstn)
                                     AW'(r_wptr - r_rptr) == r_count[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/chnl_rx_node.sv
// ============================================================================
// Module : chnl_rx_node
// Brief  : Channel receive node: accepts valid/ready words into a FWFT buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chnl_rx_node
   import chnl_pkg::*;
#(
   parameter  int DATA_W = CHNL_DATA_W,
   parameter  int DEPTH  = CHNL_DEPTH,
   parameter  int CNT_W  = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic [DATA_W-1:0] ch_data,
   input  logic              ch_valid,
   output logic              ch_ready,
   output logic              rcv_vld,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW:0]       margin,
   output logic [CNT_W-1:0]  acc_cnt
);

   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [AW:0]   w_count;
   logic [CNT_W-1:0] r_acc_cnt;

   // Ready depends only on registered state so there is no path from ch_valid.
   assign ch_ready  = rstn & en & ~w_full;
   assign w_push    = ch_valid & ch_ready;
   assign rcv_vld   = w_push;
   assign out_valid = ~w_empty;
   assign w_pop     = out_valid & out_ready;

   chnl_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (w_push),
      .wdata (ch_data),
      .pop   (w_pop),
      .rdata (out_data),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rstn)       r_acc_cnt <= '0;
      else if (w_push) r_acc_cnt <= r_acc_cnt + 1'b1;
   end

   assign acc_cnt = r_acc_cnt;
   assign margin  = c_DEPTH - w_count;

endmodule

`default_nettype wire

// File: tb/tb_chnl_rx_node.sv
// ============================================================================
// Module : tb_chnl_rx_node
// Brief  : Scoreboard bench for chnl_rx_node; queue holds words awaiting pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chnl_rx_node;

   localparam int c_DEPTH = 32;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [7:0] ch_data;
   logic       ch_valid;
   logic       ch_ready;
   logic       rcv_vld;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] margin;
   logic [15:0] acc_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  sb_q[$];
   logic [15:0] m_acc = '0;

   chnl_rx_node dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .ch_data   (ch_data),
      .ch_valid  (ch_valid),
      .ch_ready  (ch_ready),
      .rcv_vld   (rcv_vld),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .margin    (margin),
      .acc_cnt   (acc_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare outputs mid-cycle, then advance the model across the next posedge.
   task automatic cycle();
      logic exp_ready;
      logic push;
      logic pop;
      logic [7:0] head;
      #1;
      exp_ready = rstn && en && (sb_q.size() != c_DEPTH);
      push      = ch_valid && exp_ready;
      pop       = rstn && (sb_q.size() != 0) && out_ready;
      check("ch_ready", ch_ready, exp_ready);
      check("rcv_vld", rcv_vld, push);
      check("out_valid", out_valid, sb_q.size() != 0);
      check("margin", margin, c_DEPTH - sb_q.size());
      check("acc_cnt", acc_cnt, m_acc);
      if (sb_q.size() != 0) check("out_data", out_data, sb_q[0]);
      if (pop) head = sb_q.pop_front();
      if (push) begin
         sb_q.push_back(ch_data);
         m_acc++;
      end
      if (!rstn) begin
         sb_q.delete();
         m_acc = '0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; ch_data = 8'h00; ch_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset held with valid asserted
      repeat (3) cycle();
      rstn = 1'b1; ch_valid = 1'b0;
      cycle();
      check("rst_margin", margin, 32);

      // Single word
      ch_data = 8'hA5; ch_valid = 1'b1;
      cycle();
      ch_valid = 1'b0;
      cycle();
      check("single_data", out_data, 8'hA5);
      check("single_margin", margin, 31);
      out_ready = 1'b1;
      repeat (2) cycle();
      out_ready = 1'b0;

      // Fill to full, hold valid, then drain in order
      for (int i = 0; i < 32; i++) begin
         ch_data = 8'(i); ch_valid = 1'b1;
         cycle();
      end
      ch_data = 8'hEE;
      repeat (5) cycle();
      check("full_margin", margin, 0);
      ch_valid = 1'b0; out_ready = 1'b1;
      repeat (33) cycle();
      out_ready = 1'b0;

      // Full with pop in the same cycle: no push until next cycle
      for (int i = 0; i < 32; i++) begin
         ch_data = 8'(8'h40 + i); ch_valid = 1'b1;
         cycle();
      end
      ch_data = 8'h77; out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      cycle();
      check("full_pop_margin", margin, 0);
      ch_valid = 1'b0; out_ready = 1'b1;
      repeat (33) cycle();

      // Streaming after a fresh reset
      rstn = 1'b0; out_ready = 1'b0;
      cycle();
      rstn = 1'b1; out_ready = 1'b1; ch_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ch_data = 8'($urandom_range(0, 255));
         cycle();
      end
      check("stream_acc", acc_cnt, 100);
      check("stream_margin", margin, 31);

      // en drop with words buffered, then reset mid-drain
      ch_valid = 1'b0;
      cycle();
      out_ready = 1'b0; ch_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ch_data = 8'(8'hC0 + i);
         cycle();
      end
      en = 1'b0;
      cycle();
      out_ready = 1'b1;
      repeat (2) cycle();
      rstn = 1'b0;
      cycle();
      rstn = 1'b1; en = 1'b1; ch_valid = 1'b0;
      cycle();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_margin", margin, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
